// File: rtl/array_element_streamer_if.sv
// -----------------------------------------------------------------------------
// array_element_streamer_if
// Bundles the two valid/ready links of the array element streamer.
//   in_valid / in_ready / in_array       : packed array in, one array per handshake
//   out_valid / out_ready / out_elem     : element stream out, index 0 first
//   out_last                             : marks element NUM_ELEMS-1
//   out_idx                              : element index (only when the macro
//                                          ARRAY_STREAM_IDX_EN is defined)
// Modports:
//   slave  - the streamer itself
//   master - the surrounding producer/consumer (or a testbench)
// -----------------------------------------------------------------------------
interface array_element_streamer_if #(
   parameter int ELEM_W    = 33,
   parameter int NUM_ELEMS = 4
);
   localparam int IDX_W = $clog2((NUM_ELEMS > 2) ? NUM_ELEMS : 2);

   logic                          in_valid;
   logic                          in_ready;
   logic [ELEM_W*NUM_ELEMS-1:0]   in_array;
   logic                          out_valid;
   logic                          out_ready;
   logic [ELEM_W-1:0]             out_elem;
   logic                          out_last;
`ifdef ARRAY_STREAM_IDX_EN
   logic [IDX_W-1:0]              out_idx;

   modport slave (
      input  in_valid, in_array, out_ready,
      output in_ready, out_valid, out_elem, out_last, out_idx
   );

   modport master (
      output in_valid, in_array, out_ready,
      input  in_ready, out_valid, out_elem, out_last, out_idx
   );
`else
   modport slave (
      input  in_valid, in_array, out_ready,
      output in_ready, out_valid, out_elem, out_last
   );

   modport master (
      output in_valid, in_array, out_ready,
      input  in_ready, out_valid, out_elem, out_last
   );
`endif
endinterface

// File: rtl/array_element_streamer.sv
// -----------------------------------------------------------------------------
// array_element_streamer
// Captures one packed array of NUM_ELEMS elements per input handshake and
// streams the elements out one per beat, index 0 first.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   strm_io   : array_element_streamer_if.slave (input array link + output
//               element link, see the interface header)
// Optional feature macro: ARRAY_STREAM_IDX_EN adds the registered out_idx port.
// All outputs are registered except in_ready, which is combinational so a new
// array can be captured on the same cycle the last element is accepted.
// -----------------------------------------------------------------------------
module array_element_streamer #(
   parameter int ELEM_W    = 33,
   parameter int NUM_ELEMS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   array_element_streamer_if.slave  strm_io
);
   localparam int ARR_W = ELEM_W * NUM_ELEMS;
   localparam int IDX_W = $clog2((NUM_ELEMS > 2) ? NUM_ELEMS : 2);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ARR_W-1:0]    buf_q, buf_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                valid_q, valid_d;
   logic [ELEM_W-1:0]   elem_q, elem_d;
   logic                last_q, last_d;

   logic                finish_s;
   logic                advance_s;
   logic                capture_s;
   logic                in_ready_s;
   logic [IDX_W-1:0]    next_idx_s;
   logic [ELEM_W-1:0]   buf_elems_s [NUM_ELEMS];

   // Element view of the captured array buffer
   for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_elems
      assign buf_elems_s[g] = buf_q[g*ELEM_W +: ELEM_W];
   end

   // Handshake decode: the last element leaving frees the buffer this cycle
   assign finish_s   = valid_q & strm_io.out_ready & last_q;
   assign advance_s  = valid_q & strm_io.out_ready & ~last_q;
   assign capture_s  = strm_io.in_valid & in_ready_s;
   assign next_idx_s = idx_q + IDX_W'(1);

   // Input readiness: free when idle, or when the final beat is being accepted
   always_comb begin
      in_ready_s = 1'b0;
      case (state_q)
         ST_IDLE:   in_ready_s = 1'b1;
         ST_STREAM: in_ready_s = finish_s;
         default:   in_ready_s = 1'b0;
      endcase
   end

   // Next-state: capture has priority so back-to-back arrays stream without a bubble
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      elem_d  = elem_q;
      last_d  = last_q;
      if (capture_s) begin
         state_d = ST_STREAM;
         buf_d   = strm_io.in_array;
         idx_d   = {IDX_W{1'b0}};
         valid_d = 1'b1;
         elem_d  = strm_io.in_array[ELEM_W-1:0];
         last_d  = (LAST_IDX == {IDX_W{1'b0}});
      end else if (advance_s) begin
         idx_d   = next_idx_s;
         elem_d  = buf_elems_s[next_idx_s];
         last_d  = (next_idx_s == LAST_IDX);
      end else if (finish_s) begin
         // out_elem and idx keep their last values; only the link goes idle
         state_d = ST_IDLE;
         valid_d = 1'b0;
         last_d  = 1'b0;
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         buf_q   <= {ARR_W{1'b0}};
         idx_q   <= {IDX_W{1'b0}};
         valid_q <= 1'b0;
         elem_q  <= {ELEM_W{1'b0}};
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         elem_q  <= elem_d;
         last_q  <= last_d;
      end
   end

   assign strm_io.in_ready  = in_ready_s;
   assign strm_io.out_valid = valid_q;
   assign strm_io.out_elem  = elem_q;
   assign strm_io.out_last  = last_q;
`ifdef ARRAY_STREAM_IDX_EN
   assign strm_io.out_idx   = idx_q;
`endif

endmodule

// File: tb/tb_array_element_streamer.sv
// -----------------------------------------------------------------------------
// tb_array_element_streamer
// Scoreboard bench: every accepted input array is expanded into its expected
// beats (element, last flag, index) and queued; a negedge monitor pops and
// compares on every output handshake, checks stability while stalled, and
// checks out_valid / in_ready against the number of beats still outstanding.
// -----------------------------------------------------------------------------
module tb_array_element_streamer;
   localparam int ELEM_W    = 33;
   localparam int NUM_ELEMS = 4;
   localparam int ARR_W     = ELEM_W * NUM_ELEMS;

   typedef struct {
      logic [ELEM_W-1:0] elem;
      logic              last;
      int                idx;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   beat_t exp_q[$];

   array_element_streamer_if #(.ELEM_W(ELEM_W), .NUM_ELEMS(NUM_ELEMS)) bus ();

   array_element_streamer #(.ELEM_W(ELEM_W), .NUM_ELEMS(NUM_ELEMS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .strm_io (bus)
   );

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted array yields NUM_ELEMS beats, index 0 first
   function automatic void push_array(input logic [ARR_W-1:0] a);
      beat_t b;
      for (int i = 0; i < NUM_ELEMS; i++) begin
         b.elem = a[i*ELEM_W +: ELEM_W];
         b.last = (i == NUM_ELEMS - 1);
         b.idx  = i;
         exp_q.push_back(b);
      end
   endfunction

   function automatic logic [ARR_W-1:0] rand_array();
      logic [ARR_W-1:0] a;
      for (int i = 0; i < NUM_ELEMS; i++) begin
         a[i*ELEM_W +: ELEM_W] = {1'($urandom), 32'($urandom)};
      end
      return a;
   endfunction

   // Monitor: compares every output beat and handshake signal with the scoreboard
   logic [ELEM_W-1:0] st_elem;
   logic              st_last;
   logic [63:0]       st_idx;
   bit                stalled = 1'b0;
   always @(negedge clk) begin
      beat_t b;
      if (mon_en && rst_n) begin
         chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
         chk("in_ready", 64'(bus.in_ready),
             64'((exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_ready)));
         if (stalled) begin
            chk("stall_valid", 64'(bus.out_valid), 64'(1));
            chk("stall_elem", 64'(bus.out_elem), 64'(st_elem));
            chk("stall_last", 64'(bus.out_last), 64'(st_last));
`ifdef ARRAY_STREAM_IDX_EN
            chk("stall_idx", 64'(bus.out_idx), st_idx);
`endif
         end
         if (bus.out_valid && bus.out_ready) begin
            stalled = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat actual=%0h expected=none at %0t", bus.out_elem, $time);
            end else begin
               b = exp_q.pop_front();
               chk("beat_elem", 64'(bus.out_elem), 64'(b.elem));
               chk("beat_last", 64'(bus.out_last), 64'(b.last));
`ifdef ARRAY_STREAM_IDX_EN
               chk("beat_idx", 64'(bus.out_idx), 64'(b.idx));
`endif
            end
         end else if (bus.out_valid) begin
            stalled = 1'b1;
            st_elem = bus.out_elem;
            st_last = bus.out_last;
`ifdef ARRAY_STREAM_IDX_EN
            st_idx  = 64'(bus.out_idx);
`else
            st_idx  = 64'(0);
`endif
         end else begin
            stalled = 1'b0;
         end
      end else begin
         stalled = 1'b0;
      end
   end

   // One clock of stimulus; entered and left at posedge+1
   task automatic step(input bit v, input logic [ARR_W-1:0] a, input bit r, output bit acc);
      bus.in_valid  = v;
      bus.in_array  = a;
      bus.out_ready = r;
      @(negedge clk);
      #1;
      acc = v && bus.in_ready;
      if (acc) push_array(a);
      @(posedge clk);
      #1;
   endtask

   // Random traffic phase; upstream holds its array until it is taken
   task automatic run_phase(input int cycles, input int vld_pct, input int mode);
      bit               acc;
      bit               v;
      bit               r;
      logic [ARR_W-1:0] a;
      acc = 1'b1;
      v   = 1'b0;
      a   = rand_array();
      for (int k = 0; k < cycles; k++) begin
         if (acc || !v) begin
            v = ($urandom_range(99) < vld_pct);
            a = rand_array();
         end
         case (mode)
            0:       r = 1'b1;
            1:       r = ((k % 3) == 0);
            default: r = 1'($urandom);
         endcase
         step(v, a, r, acc);
      end
   endtask

   task automatic drain();
      bit acc;
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
         step(1'b0, {ARR_W{1'b0}}, 1'b1, acc);
      end
      step(1'b0, {ARR_W{1'b0}}, 1'b1, acc);
      chk("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      bit               acc;
      logic [ARR_W-1:0] arr;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_array  = {ARR_W{1'b0}};
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_out_elem", 64'(bus.out_elem), 64'(0));
      chk("rst_out_last", 64'(bus.out_last), 64'(0));
`ifdef ARRAY_STREAM_IDX_EN
      chk("rst_out_idx", 64'(bus.out_idx), 64'(0));
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Single known array with continuous out_ready
      arr = {33'h3, 33'h2, 33'h1, 33'h0_0000_002a};
      step(1'b1, arr, 1'b1, acc);
      chk("single_accept", 64'(acc), 64'(1));
      drain();

      // Backpressure 1,0,0 pattern, continuous back-to-back, then random
      run_phase(120, 60, 1);
      drain();
      run_phase(80, 100, 0);
      drain();
      run_phase(1500, 50, 2);
      drain();

      // Asynchronous reset after the first beat has been accepted
      arr = rand_array();
      step(1'b1, arr, 1'b1, acc);
      step(1'b0, {ARR_W{1'b0}}, 1'b1, acc);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("async_rst_valid", 64'(bus.out_valid), 64'(0));
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      arr = rand_array();
      step(1'b1, arr, 1'b1, acc);
      chk("post_rst_accept", 64'(acc), 64'(1));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
